cla_5bit: RTL and testbench

- 5-bit carry-lookahead adder: {C_out, Sum} = A + B + C_in.
- Primary result is purely combinational and settles within one 10 ns stimulus step. No clock is needed to see it.
- Registered copies of the result and flags are also provided, for datapaths that need a pipelined result.
- Used as a leaf arithmetic block. It can be cascaded through the group propagate/generate outputs.

---
 rtl/cla_5bit.sv | 86 ++++++++
 tb/tb_cla_5bit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cla_5bit.sv
// rtl/cla_5bit.sv - 5-bit carry-lookahead adder with registered result copies
// Optional parity outputs Par/Par_r are built when CLA_5BIT_PARITY_EN is defined.
module cla_5bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       C_in,
  output logic [4:0] Sum,
  output logic       C_out,
  output logic       P_grp,
  output logic       G_grp,
  output logic       Ovf,
`ifdef CLA_5BIT_PARITY_EN
  output logic       Par,
  output logic       Par_r,
`endif
  output logic [4:0] Sum_r,
  output logic       C_out_r,
  output logic       Ovf_r
);

  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat sum of products of g, p and C_in; none feeds another.
  assign c[0] = C_in;
  assign c[1] = g[0]
              | (p[0] & C_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & C_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & C_in);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & C_in);
  assign c[5] = g[4]
              | (p[4] & g[3])
              | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & C_in);

  // Group terms let a wider adder cascade this block as one lookahead digit.
  assign G_grp = g[4]
               | (p[4] & g[3])
               | (p[4] & p[3] & g[2])
               | (p[4] & p[3] & p[2] & g[1])
               | (p[4] & p[3] & p[2] & p[1] & g[0]);
  assign P_grp = &p;

  assign Sum   = p ^ c[4:0];
  assign C_out = c[5];
  assign Ovf   = c[4] ^ c[5];

`ifdef CLA_5BIT_PARITY_EN
  assign Par = ^Sum;

  always_ff @(posedge clk) begin
    if (rst) Par_r <= 1'b0;
    else     Par_r <= Par;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_r   <= 5'd0;
      C_out_r <= 1'b0;
      Ovf_r   <= 1'b0;
    end else begin
      Sum_r   <= Sum;
      C_out_r <= C_out;
      Ovf_r   <= Ovf;
    end
  end

endmodule

// File: tb/tb_cla_5bit.sv
// tb/tb_cla_5bit.sv - scoreboard bench for cla_5bit against an arithmetic reference model
module tb_cla_5bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] A = 5'd0;
  logic [4:0] B = 5'd0;
  logic       C_in = 1'b0;
  logic [4:0] Sum;
  logic       C_out, P_grp, G_grp, Ovf;
  logic [4:0] Sum_r;
  logic       C_out_r, Ovf_r;
`ifdef CLA_5BIT_PARITY_EN
  logic       Par, Par_r;
`endif

  cla_5bit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C_in(C_in),
    .Sum(Sum), .C_out(C_out), .P_grp(P_grp), .G_grp(G_grp), .Ovf(Ovf),
`ifdef CLA_5BIT_PARITY_EN
    .Par(Par), .Par_r(Par_r),
`endif
    .Sum_r(Sum_r), .C_out_r(C_out_r), .Ovf_r(Ovf_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sum;
    logic       cout, pg, gg, ovf, par;
  } comb_t;

  typedef struct {
    logic [4:0] sum;
    logic       cout, ovf, par;
    int         check_at;
  } reg_t;

  comb_t cq[$];
  reg_t  rq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d A=%0d B=%0d C_in=%0d rst=%0d got=%0h want=%0h",
               name, cyc, A, B, C_in, rst, got, want);
    end
  endtask

  function automatic comb_t model(input int a, input int b, input int ci);
    comb_t e;
    int total, sa, sb, ssum;
    total  = a + b + ci;
    e.sum  = 5'(total % 32);
    e.cout = (total >= 32);
    e.pg   = ((a ^ b) == 31);
    e.gg   = ((a + b) >= 32);
    sa     = (a >= 16) ? a - 32 : a;
    sb     = (b >= 16) ? b - 32 : b;
    ssum   = sa + sb + ci;
    e.ovf  = (ssum > 15) || (ssum < -16);
    e.par  = ($countones(e.sum) % 2) == 1;
    return e;
  endfunction

  task automatic apply(input int a, input int b, input int ci, input logic r);
    comb_t e;
    reg_t  q;
    @(posedge clk);
    #1;
    A = 5'(a); B = 5'(b); C_in = ci[0]; rst = r;
    e = model(a, b, ci);
    cq.push_back(e);
    q.sum      = r ? 5'd0 : e.sum;
    q.cout     = r ? 1'b0 : e.cout;
    q.ovf      = r ? 1'b0 : e.ovf;
    q.par      = r ? 1'b0 : e.par;
    q.check_at = cyc + 1;
    rq.push_back(q);
  endtask

  always @(negedge clk) begin
    comb_t e;
    reg_t  q;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      check("sum",   {3'b0, Sum},   {3'b0, e.sum});
      check("c_out", {7'b0, C_out}, {7'b0, e.cout});
      check("p_grp", {7'b0, P_grp}, {7'b0, e.pg});
      check("g_grp", {7'b0, G_grp}, {7'b0, e.gg});
      check("ovf",   {7'b0, Ovf},   {7'b0, e.ovf});
`ifdef CLA_5BIT_PARITY_EN
      check("par",   {7'b0, Par},   {7'b0, e.par});
`endif
    end
    while (rq.size() > 0 && rq[0].check_at <= cyc) begin
      q = rq.pop_front();
      check("sum_r",   {3'b0, Sum_r},   {3'b0, q.sum});
      check("c_out_r", {7'b0, C_out_r}, {7'b0, q.cout});
      check("ovf_r",   {7'b0, Ovf_r},   {7'b0, q.ovf});
`ifdef CLA_5BIT_PARITY_EN
      check("par_r",   {7'b0, Par_r},   {7'b0, q.par});
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply(0, 0, 0, 1'b1);
    apply(0, 0, 0, 1'b0);
    apply(31, 31, 1, 1'b0);
    apply(31, 0, 1, 1'b0);
    apply(15, 1, 0, 1'b0);
    // registered path: capture, clear for one edge, resume
    apply(12, 9, 1, 1'b0);
    apply(12, 9, 1, 1'b0);
    apply(12, 9, 1, 1'b1);
    apply(12, 9, 1, 1'b0);
    apply(12, 9, 1, 1'b0);
    for (int ci = 0; ci < 2; ci++)
      for (int a = 0; a < 32; a++)
        for (int b = 0; b < 32; b++)
          apply(a, b, ci, 1'b0);
    for (int i = 0; i < 300; i++)
      apply(int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(1)), ($urandom_range(15) == 0));
    repeat (3) @(posedge clk);
    #2;
    check("drain", 8'(cq.size() + rq.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
